// File: rtl/uart_tx_fifo_pkg.sv
// uart_pkg: shared types and helpers for the buffered UART transmitter.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    ,
    TX_BREAK  = 3'd5
`endif
  } tx_state_e;

  // Clock cycles per bit, truncated toward zero.
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock show-ahead FIFO with occupancy count.
// Pushes while full and pops while empty are ignored; pointers wrap
// naturally because DEPTH is a power of two.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Advance pointers and occupancy for accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Control state: cleared on reset, which also discards stored words.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array: written only on an accepted push, never reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter. Words queue in a FIFO and are
// sent back-to-back; parity and stop-bit count are latched per frame.
// Define UART_TX_BREAK_EN to add the break_req input and BREAK state.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD_RATE      = 115200,
  parameter int VLD_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          CLK,
  input  logic                          rst_n,
  input  logic [VLD_DATA_WIDTH-1:0]     din,
  input  logic                          wr_en,
  output logic                          wr_ready,
  input  logic [1:0]                    parity_sel,
  input  logic                          stop_sel,
`ifdef UART_TX_BREAK_EN
  input  logic                          break_req,
`endif
  output logic                          TX,
  output logic                          TX_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W    = $clog2(BAUD_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(VLD_DATA_WIDTH - 1);

  localparam logic [2:0] ST_IDLE   = TX_IDLE;
  localparam logic [2:0] ST_START  = TX_START;
  localparam logic [2:0] ST_DATA   = TX_DATA;
  localparam logic [2:0] ST_PARITY = TX_PARITY;
  localparam logic [2:0] ST_STOP   = TX_STOP;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] ST_BREAK  = TX_BREAK;
  // Bit slots 0..W+3 are held low, slot W+4 is the trailing high mark.
  localparam logic [3:0] BRK_HIGH  = 4'(VLD_DATA_WIDTH + 4);
`endif

  logic [2:0]                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [3:0]                bit_q, bit_d;
  logic [VLD_DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                      par_bit_q, par_bit_d;
  logic                      par_en_q, par_en_d;
  logic                      stop2_q, stop2_d;
  logic                      tx_q, tx_d;
  logic                      tick, launch;
  logic [VLD_DATA_WIDTH-1:0] fifo_dout;
  logic                      fifo_full, fifo_empty;

  function automatic logic parity_bit(input logic [VLD_DATA_WIDTH-1:0] d,
                                      input logic [1:0] sel);
    return (sel == PAR_ODD) ? ~^d : ^d;
  endfunction

  uart_sync_fifo #(
    .WIDTH (VLD_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (rst_n),
    .push_i  (wr_en),
    .din_i   (din),
    .pop_i   (launch),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign wr_ready = ~fifo_full;
  assign overflow = wr_en & fifo_full;
  assign TX       = tx_q;
  assign TX_busy  = (state_q != ST_IDLE);
  assign tick     = (cnt_q == CNT_LAST);

  // Frame sequencer: bit boundaries only on baud terminal count; a new
  // frame is launched from IDLE or straight out of the last stop bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    launch    = 1'b0;
    if (state_q != ST_IDLE) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          state_d = ST_BREAK;
          bit_d   = '0;
        end else begin
          launch = ~fifo_empty;
        end
`else
        launch = ~fifo_empty;
`endif
      end
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA: if (tick) begin
        shreg_d = shreg_q >> 1;
        if (bit_q == DATA_LAST) begin
          bit_d   = '0;
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP: if (tick) begin
        if (stop2_q && (bit_q == '0)) begin
          bit_d = 4'd1;
        end else if (!fifo_empty) begin
          launch = 1'b1;
        end else begin
          state_d = ST_IDLE;
          bit_d   = '0;
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: if (tick) begin
        if (bit_q == BRK_HIGH) begin
          state_d = ST_IDLE;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (launch) begin
      state_d   = ST_START;
      cnt_d     = '0;
      bit_d     = '0;
      shreg_d   = fifo_dout;
      par_en_d  = (parity_sel == PAR_ODD) || (parity_sel == PAR_EVEN);
      par_bit_d = parity_bit(fifo_dout, parity_sel);
      stop2_d   = stop_sel;
    end
  end

  // Line level for the next cycle, derived from the next state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_bit_d;
`ifdef UART_TX_BREAK_EN
      ST_BREAK:  tx_d = (bit_d == BRK_HIGH);
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // Control registers: reset aborts any frame and idles the line high.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
    end
  end

  // Frame data registers: always loaded before use, so no reset needed.
  always_ff @(posedge CLK) begin
    shreg_q   <= shreg_d;
    par_bit_q <= par_bit_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized checks of uart_tx_fifo against a
// frame-level reference (word queue + bit-centre line sampling).
// Break scenario is included when UART_TX_BREAK_EN is defined.
module tb_uart_tx_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int BD    = 86;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic       wr_ready;
  logic [1:0] parity_sel = 2'b00;
  logic       stop_sel = 1'b0;
  logic       TX, TX_busy;
  logic [4:0] fifo_level;
  logic       overflow;
`ifdef UART_TX_BREAK_EN
  logic       break_req = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int   busy_cyc = 0;
  int   lvl_max  = 0;
  bit   mon_hold = 1'b0;
  bit   mon_active = 1'b0;
  int   mon_cnt, mon_idx, mon_n;
  logic [15:0] mon_exp, mon_got;
  logic [7:0]  mon_w;

  always #5 CLK = ~CLK;

  uart_tx_fifo #(
    .CLK_FREQ       (10_000_000),
    .BAUD_RATE      (115200),
    .VLD_DATA_WIDTH (W),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .din        (din),
    .wr_en      (wr_en),
    .wr_ready   (wr_ready),
    .parity_sel (parity_sel),
    .stop_sel   (stop_sel),
`ifdef UART_TX_BREAK_EN
    .break_req  (break_req),
`endif
    .TX         (TX),
    .TX_busy    (TX_busy),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line bits of one frame, start bit at index 0; returns bit count.
  function automatic int frame_bits(input logic [7:0] w, input logic [1:0] ps,
                                    input logic ss, output logic [15:0] bits);
    int n;
    int ones;
    ones = $countones(w);
    bits = '1;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < W; i++) begin
      bits[n] = w[i];
      n++;
    end
    if (ps == 2'b01) begin
      bits[n] = ((ones % 2) == 0);
      n++;
    end else if (ps == 2'b10) begin
      bits[n] = ((ones % 2) == 1);
      n++;
    end
    n += ss ? 2 : 1;
    return n;
  endfunction

  // Line receiver: locks onto a start bit, samples each bit at its centre.
  task automatic monitor();
    if (!rst_n || mon_hold) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (TX === 1'b0) begin
        check("start_has_queued_word", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_w      = exp_q.pop_front();
          mon_n      = frame_bits(mon_w, parity_sel, stop_sel, mon_exp);
          mon_got    = '1;
          mon_got[0] = 1'b0;
          mon_idx    = 1;
          mon_cnt    = 0;
          mon_active = 1'b1;
        end
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == mon_idx * BD + BD / 2) begin
        mon_got[mon_idx] = TX;
        mon_idx++;
        if (mon_idx == mon_n) begin
          check($sformatf("frame_%02h", mon_w), 32'(mon_got), 32'(mon_exp));
          mon_active = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge CLK);
    monitor();
    if (TX_busy === 1'b1) busy_cyc++;
    if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    bit acc;
    acc   = (exp_q.size() < DEPTH);
    din   = w;
    wr_en = 1'b1;
    #1;
    check("push_wr_ready", wr_ready, acc);
    check("push_overflow", overflow, !acc);
    if (acc) exp_q.push_back(w);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((TX_busy !== 1'b0 || exp_q.size() != 0 || mon_active) && n < limit) begin
      step();
      n++;
    end
    check("idle_reached", n < limit, 1'b1);
  endtask

  initial begin
    int lows;
    int hi;
    int nw;

    // Reset values
    repeat (3) step();
    check("rst_tx", TX, 1'b1);
    check("rst_busy", TX_busy, 1'b0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // Odd parity, one stop, latency and frame length
    parity_sel = 2'b01; stop_sel = 1'b0; busy_cyc = 0;
    push(8'hAB);
    check("t1_tx_before", TX, 1'b1);
    check("t1_busy_before", TX_busy, 1'b0);
    check("t1_level_1", fifo_level, 1);
    step();
    check("t1_tx_fall", TX, 1'b0);
    check("t1_busy_rise", TX_busy, 1'b1);
    check("t1_level_0", fifo_level, 0);
    wait_idle(5000);
    check("t1_busy_cycles", busy_cyc, 946);

    // Even parity, two stops, three words back-to-back
    parity_sel = 2'b10; stop_sel = 1'b1; busy_cyc = 0; lvl_max = 0;
    push(8'hAB);
    push(8'hCD);
    push(8'hEF);
    wait_idle(10000);
    check("t2_busy_cycles", busy_cyc, 3096);
    check("t2_level_peak", lvl_max, 2);

    // Overflow with the FIFO full while busy
    parity_sel = 2'b01; stop_sel = 1'b0;
    push(8'($urandom_range(0, 255)));
    step();
    for (int i = 0; i < DEPTH; i++) push(8'($urandom_range(0, 255)));
    check("t3_level_full", fifo_level, 16);
    check("t3_wr_ready_low", wr_ready, 1'b0);
    push(8'h5A);
    #1;
    check("t3_overflow_clears", overflow, 1'b0);
    check("t3_level_held", fifo_level, 16);
    wait_idle(20000);

    // No parity, one stop; parity change mid-frame must not matter
    parity_sel = 2'b00; stop_sel = 1'b0; busy_cyc = 0;
    push(8'h55);
    repeat (300) step();
    parity_sel = 2'b01;
    wait_idle(5000);
    check("t4_busy_cycles", busy_cyc, 860);
    parity_sel = 2'b00;

    // Asynchronous reset in the middle of a data bit
    parity_sel = 2'b01;
    push(8'hCD);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    check("t5_level_3", fifo_level, 3);
    repeat (250) step();
    rst_n = 1'b0;
    #1;
    check("t5_tx_async", TX, 1'b1);
    check("t5_busy_async", TX_busy, 1'b0);
    check("t5_level_async", fifo_level, 0);
    check("t5_wr_ready_async", wr_ready, 1'b1);
    exp_q.delete();
    repeat (3) step();
    rst_n = 1'b1;
    lows = 0;
    repeat (300) begin
      step();
      if (TX !== 1'b1) lows++;
    end
    check("t5_tx_stays_idle", lows, 0);
    check("t5_busy_after", TX_busy, 1'b0);
    check("t5_level_after", fifo_level, 0);

    // Randomized words, framing and mid-stream config changes
    for (int i = 0; i < 6; i++) begin
      parity_sel = 2'($urandom_range(0, 3));
      stop_sel   = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 3);
      for (int j = 0; j < nw; j++) begin
        push(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2)) step();
      end
      repeat ($urandom_range(0, 400)) step();
      parity_sel = 2'($urandom_range(0, 3));
      stop_sel   = 1'($urandom_range(0, 1));
      wait_idle(20000);
    end

`ifdef UART_TX_BREAK_EN
    // Break: low for W+4 bits, high one bit, then the queued word
    parity_sel = 2'b00; stop_sel = 1'b0; mon_hold = 1'b1;
    break_req = 1'b1;
    push(8'h3C);
    break_req = 1'b0;
    check("t6_busy", TX_busy, 1'b1);
    check("t6_level_kept", fifo_level, 1);
    lows = 0;
    while (TX === 1'b0 && lows < 2000) begin
      lows++;
      step();
    end
    check("t6_low_cycles", lows, 1032);
    hi = 0;
    repeat (BD) begin
      if (TX === 1'b1 && TX_busy === 1'b1) hi++;
      step();
    end
    check("t6_high_cycles", hi, BD);
    check("t6_level_after_break", fifo_level, 1);
    mon_hold = 1'b0;
    wait_idle(5000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
